comp_mult_seq: RTL and testbench

COMP_MULT_SEQ -- requirements
Module: comp_mult_seq

---
 rtl/comp_mult_seq.sv | 168 ++++++++++++++++
 tb/tb_comp_mult_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_mult_seq.sv
// Complex-multiply job sequencer: fetches operand pairs from memory, hands them to an external
// multiplier and writes sign-extended results back. Optional start-time range check: COMP_MULT_SEQ_RANGE_CHK_EN.
module comp_mult_seq #(
  parameter int DWIDTH = 8,
  parameter int SYS_AW = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sw_rst,
  input  logic [SYS_AW-1:0]         op1_ba,
  input  logic [SYS_AW-1:0]         op2_ba,
  input  logic [SYS_AW-1:0]         res_ba,
  input  logic [15:0]               nr_op,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      mem_ce,
  output logic                      mem_we,
  output logic [SYS_AW-1:0]         mem_addr,
  output logic [DWIDTH-1:0]         mem_wr_data,
  input  logic [DWIDTH-1:0]         mem_rd_data,
  output logic                      op_val,
  input  logic                      op_rdy,
  output logic [4*DWIDTH-1:0]       op_data,
  input  logic                      res_val,
  output logic                      res_rdy,
  input  logic [2*(2*DWIDTH+1)-1:0] res_data
);
  localparam int RW = 2*DWIDTH+1;
  localparam int EW = 3*DWIDTH;

  typedef enum logic [2:0] {IDLE, RD, CAP, OPV, RESW, WR, DONE} state_t;

  state_t               state, next_state;
  logic [2:0]           cnt;
  logic [15:0]          ops_left;
  logic [SYS_AW-1:0]    op1_ptr, op2_ptr, res_ptr;
  logic [DWIDTH-1:0]    opw_p0 [4];
  logic signed [RW-1:0] xr_p1, yr_p1;
  logic [6*DWIDTH-1:0]  res_words;
  logic                 accept, range_err;

  function automatic logic [EW-1:0] sext(input logic signed [RW-1:0] v);
    logic signed [EW-1:0] w;
    w = EW'(v);
    return w;
  endfunction

  assign accept = (state == IDLE) && start;

`ifdef COMP_MULT_SEQ_RANGE_CHK_EN
  localparam int XW = SYS_AW + 20;
  logic [XW-1:0] op1_end, op2_end, res_end;
  logic          err_q;

  // Last address touched by each region, computed wide enough that overflow is visible.
  always_comb begin
    op1_end   = XW'(op1_ba) + (XW'(nr_op) << 1) - XW'(1);
    op2_end   = XW'(op2_ba) + (XW'(nr_op) << 1) - XW'(1);
    res_end   = XW'(res_ba) + XW'(nr_op) * XW'(6) - XW'(1);
    range_err = (nr_op != 16'd0) &&
                (((op1_end >> SYS_AW) != '0) || ((op2_end >> SYS_AW) != '0) ||
                 ((res_end >> SYS_AW) != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (sw_rst) err_q <= 1'b0;
    else if (accept) err_q <= range_err;
  end
  assign err = err_q;
`else
  assign range_err = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      ops_left <= 16'd0;
      op1_ptr  <= '0;
      op2_ptr  <= '0;
      res_ptr  <= '0;
    end else if (sw_rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      ops_left <= 16'd0;
      op1_ptr  <= '0;
      op2_ptr  <= '0;
      res_ptr  <= '0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state) ? 3'd0 : cnt + 3'd1;
      if (accept) begin
        ops_left <= nr_op;
        op1_ptr  <= op1_ba;
        op2_ptr  <= op2_ba;
        res_ptr  <= res_ba;
      end else if (state == WR && cnt == 3'd5) begin
        ops_left <= ops_left - 16'd1;
        op1_ptr  <= op1_ptr + SYS_AW'(2);
        op2_ptr  <= op2_ptr + SYS_AW'(2);
        res_ptr  <= res_ptr + SYS_AW'(6);
      end
    end
  end

  // Stage p0: read data lands one cycle after each read; stage p1: multiplier result capture.
  always_ff @(posedge clk) begin
    if (state == RD && cnt != 3'd0) opw_p0[cnt[1:0] - 2'd1] <= mem_rd_data;
    if (state == CAP)               opw_p0[3]               <= mem_rd_data;
    if (state == RESW && res_val) begin
      xr_p1 <= res_data[2*RW-1:RW];
      yr_p1 <= res_data[RW-1:0];
    end
  end

  assign res_words = {sext(yr_p1), sext(xr_p1)};

  always_comb begin
    next_state  = state;
    mem_ce      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    op_val      = 1'b0;
    op_data     = '0;
    res_rdy     = 1'b0;
    case (state)
      IDLE: if (start) next_state = (nr_op == 16'd0 || range_err) ? DONE : RD;
      RD: begin
        mem_ce = 1'b1;
        case (cnt[1:0])
          2'd0:    mem_addr = op1_ptr;
          2'd1:    mem_addr = op1_ptr + SYS_AW'(1);
          2'd2:    mem_addr = op2_ptr;
          default: mem_addr = op2_ptr + SYS_AW'(1);
        endcase
        if (cnt == 3'd3) next_state = CAP;
      end
      CAP: next_state = OPV;
      OPV: begin
        op_val  = 1'b1;
        op_data = {opw_p0[0], opw_p0[2], opw_p0[1], opw_p0[3]};
        if (op_rdy) next_state = RESW;
      end
      RESW: begin
        res_rdy = 1'b1;
        if (res_val) next_state = WR;
      end
      WR: begin
        mem_ce      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = res_ptr + SYS_AW'(cnt);
        mem_wr_data = res_words[cnt*DWIDTH +: DWIDTH];
        if (cnt == 3'd5) next_state = (ops_left == 16'd1) ? DONE : RD;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_comp_mult_seq.sv
// Directed bench for comp_mult_seq: byte memory model, handshaking multiplier model, scoreboard checks.
`timescale 1ns/1ps
module tb_comp_mult_seq;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int RW = 2*DW+1;

  logic            clk, rst_n, sw_rst, start;
  logic [AW-1:0]   op1_ba, op2_ba, res_ba;
  logic [15:0]     nr_op;
  logic            busy, done, err, mem_ce, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wr_data, mem_rd_data;
  logic            op_val, op_rdy, res_val, res_rdy;
  logic [4*DW-1:0] op_data;
  logic [2*RW-1:0] res_data;

  comp_mult_seq #(.DWIDTH(DW), .SYS_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
    .op1_ba(op1_ba), .op2_ba(op2_ba), .res_ba(res_ba), .nr_op(nr_op),
    .start(start), .busy(busy), .done(done), .err(err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .op_val(op_val), .op_rdy(op_rdy), .op_data(op_data),
    .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] opmem  [0:65535];
  logic [7:0] resmem [0:65535];
  int n_chk, n_err;
  int acc_cnt, wr_cnt, done_cnt, opv_cnt, early_wr;
  int wr_log[$];

  // Multiplier model state
  int rdy_dly, res_dly, op_cnt, res_cnt, stable_errs;
  bit pend_res;
  logic [4*DW-1:0] held_op, last_op;

  initial begin
    acc_cnt = 0; wr_cnt = 0; done_cnt = 0; opv_cnt = 0; early_wr = 0;
  end

  always @(posedge clk) begin
    if (mem_ce) acc_cnt++;
    if (mem_ce && !mem_we) mem_rd_data <= opmem[mem_addr];
    if (mem_ce && mem_we) begin
      resmem[mem_addr] <= mem_wr_data;
      wr_cnt++;
      wr_log.push_back(int'(mem_addr));
      if (pend_res) early_wr++;
    end
    if (done) done_cnt++;
    if (op_val) opv_cnt++;
  end

  function automatic logic [2*RW-1:0] cmul(input logic [4*DW-1:0] d);
    logic signed [DW-1:0] x1, x2, y1, y2;
    logic signed [RW-1:0] xr, yr;
    {x1, x2, y1, y2} = d;
    xr = x1*x2 - y1*y2;
    yr = x1*y2 + x2*y1;
    return {xr, yr};
  endfunction

  initial begin
    op_rdy = 1'b0; res_val = 1'b0; res_data = '0; pend_res = 1'b0;
    op_cnt = 0; res_cnt = 0; stable_errs = 0; held_op = '0; last_op = '0;
    forever begin
      @(negedge clk);
      if (op_rdy) begin
        op_rdy = 1'b0; pend_res = 1'b1; res_cnt = 0; op_cnt = 0;
      end else if (op_val) begin
        if (op_cnt == 0) held_op = op_data;
        else if (op_data !== held_op) stable_errs++;
        if (op_cnt >= rdy_dly) begin
          op_rdy = 1'b1; last_op = held_op; res_data = cmul(held_op);
        end
        op_cnt++;
      end else op_cnt = 0;
      if (res_val) res_val = 1'b0;
      else if (pend_res && res_rdy) begin
        if (res_cnt >= res_dly) begin res_val = 1'b1; pend_res = 1'b0; end
        res_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] a1, a2, ar, input logic [15:0] n);
    @(negedge clk);
    op1_ba = a1; op2_ba = a2; res_ba = ar; nr_op = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin @(negedge clk); c++; end
    chk("done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  function automatic logic [47:0] rd_res(input logic [AW-1:0] a);
    logic [47:0] v;
    for (int i = 0; i < 6; i++) v[8*i +: 8] = resmem[AW'(a + AW'(i))];
    return v;
  endfunction

  function automatic logic [47:0] ref_op(input int k);
    int x1, y1, x2, y2;
    logic [31:0] xr, yr;
    logic [AW-1:0] a, b;
    a = 16'h1000 + AW'(2*k);
    b = 16'h2000 + AW'(2*k);
    x1 = int'($signed(opmem[a]));  y1 = int'($signed(opmem[AW'(a+1)]));
    x2 = int'($signed(opmem[b]));  y2 = int'($signed(opmem[AW'(b+1)]));
    xr = x1*x2 - y1*y2;
    yr = x1*y2 + x2*y1;
    return {yr[23:0], xr[23:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0, v0, w0, s0, e0, lb, c;
    n_chk = 0; n_err = 0; rdy_dly = 0; res_dly = 0;
    rst_n = 1'b0; sw_rst = 1'b0; start = 1'b0;
    op1_ba = '0; op2_ba = '0; res_ba = '0; nr_op = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem", {mem_ce, mem_we, mem_addr, mem_wr_data}, '0);
    chk("rst_hs", {op_val, op_data, res_rdy}, '0);
    rst_n = 1'b1;

    // Single operation, no backpressure
    opmem[16'h0100] = 8'd1; opmem[16'h0101] = 8'd2;
    opmem[16'h0200] = 8'd3; opmem[16'h0201] = 8'd4;
    d0 = done_cnt;
    pulse_start(16'h0100, 16'h0200, 16'h0300, 16'd1);
    wait_done(100);
    chk("single_op_data", last_op, 32'h01030204);
    chk("single_result", rd_res(16'h0300), 48'h00000AFFFFFB);
    chk("single_done_once", done_cnt - d0, 1);
    chk("single_idle", busy, 1'b0);

    // Zero-length job
    a0 = acc_cnt; v0 = opv_cnt; d0 = done_cnt;
    pulse_start(16'h0100, 16'h0200, 16'h0300, 16'd0);
    chk("zero_done_pulse", done, 1'b1);
    @(negedge clk);
    chk("zero_done_low", done, 1'b0);
    chk("zero_no_mem", acc_cnt - a0, 0);
    chk("zero_no_opval", opv_cnt - v0, 0);
    chk("zero_done_once", done_cnt - d0, 1);

    // Backpressure on both handshakes
    opmem[16'h0400] = 8'hFD; opmem[16'h0401] = 8'h05;
    opmem[16'h0500] = 8'h07; opmem[16'h0501] = 8'hFE;
    rdy_dly = 5; res_dly = 3;
    s0 = stable_errs; e0 = early_wr; w0 = wr_cnt; v0 = opv_cnt;
    pulse_start(16'h0400, 16'h0500, 16'h0600, 16'd1);
    wait_done(200);
    chk("bp_op_data", last_op, 32'hFD0705FE);
    chk("bp_result", rd_res(16'h0600), 48'h000029FFFFF5);
    chk("bp_opval_cycles", opv_cnt - v0, 6);
    chk("bp_op_stable", stable_errs - s0, 0);
    chk("bp_no_early_wr", early_wr - e0, 0);
    chk("bp_writes", wr_cnt - w0, 6);
    rdy_dly = 0; res_dly = 0;

    // Ten operations; inputs change and start re-pulses mid-job
    for (int k = 0; k < 20; k++) begin
      opmem[16'h1000 + AW'(k)] = 8'($urandom);
      opmem[16'h2000 + AW'(k)] = 8'($urandom);
    end
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start(16'h1000, 16'h2000, 16'h3000, 16'd10);
    op1_ba = 16'h5000; op2_ba = 16'h6000; res_ba = 16'h7000; nr_op = 16'd3;
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1000);
    for (int k = 0; k < 10; k++)
      chk($sformatf("multi_res%0d", k), rd_res(16'h3000 + AW'(6*k)), ref_op(k));
    repeat (5) @(negedge clk);
    chk("multi_writes", wr_cnt - w0, 60);
    chk("multi_done_once", done_cnt - d0, 1);
    chk("multi_idle", busy, 1'b0);

    // Software reset during the writes of the third operation
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start(16'h1000, 16'h2000, 16'h4000, 16'd5);
    c = 0;
    while ((wr_cnt - w0) < 13 && c < 500) begin @(negedge clk); c++; end
    chk("swrst_reached_wr", mem_we, 1'b1);
    sw_rst = 1'b1;
    @(posedge clk); #1;
    chk("swrst_busy", busy, 1'b0);
    chk("swrst_mem_ce", mem_ce, 1'b0);
    @(negedge clk);
    sw_rst = 1'b0;
    a0 = acc_cnt; v0 = opv_cnt;
    repeat (30) @(negedge clk);
    chk("swrst_no_access", acc_cnt - a0, 0);
    chk("swrst_no_opval", opv_cnt - v0, 0);
    chk("swrst_no_done", done_cnt - d0, 0);

    // Hardware reset while reading
    d0 = done_cnt;
    pulse_start(16'h1000, 16'h2000, 16'h4000, 16'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("hwrst_async", {busy, mem_ce, op_val, res_rdy}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    a0 = acc_cnt;
    repeat (20) @(negedge clk);
    chk("hwrst_no_access", acc_cnt - a0, 0);
    chk("hwrst_no_done", done_cnt - d0, 0);

    // Result region reaching the top of the address space
    lb = wr_log.size(); a0 = acc_cnt; d0 = done_cnt;
    pulse_start(16'h0100, 16'h0200, 16'hFFFC, 16'd1);
    wait_done(100);
    chk("range_done_once", done_cnt - d0, 1);
`ifdef COMP_MULT_SEQ_RANGE_CHK_EN
    chk("range_err_set", err, 1'b1);
    chk("range_no_access", acc_cnt - a0, 0);
    pulse_start(16'h0100, 16'h0200, 16'h0300, 16'd1);
    wait_done(100);
    chk("range_err_cleared", err, 1'b0);
    chk("range_retry_result", rd_res(16'h0300), 48'h00000AFFFFFB);
`else
    chk("wrap_err_zero", err, 1'b0);
    chk("wrap_write_count", wr_log.size() - lb, 6);
    if (wr_log.size() - lb >= 6)
      for (int i = 0; i < 6; i++)
        chk($sformatf("wrap_addr%0d", i), wr_log[lb+i], (32'hFFFC + i) & 32'hFFFF);
    chk("wrap_result", rd_res(16'hFFFC), 48'h00000AFFFFFB);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
